// File: rtl/fft_input_framer.sv
// Serial-to-parallel frame collector feeding the 8-point FFT core, with one staged frame and hold back-pressure.
// Optional FRAMER_BITREV_EN: emit the staged frame in bit-reversed order for a decimation-in-time core.
module fft_input_framer #(
  parameter int DATA_W = 16,
  parameter int NPTS   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              hold,
  input  logic              flush,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] x0,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] x2,
  output logic [DATA_W-1:0] x3,
  output logic [DATA_W-1:0] x4,
  output logic [DATA_W-1:0] x5,
  output logic [DATA_W-1:0] x6,
  output logic [DATA_W-1:0] x7,
  output logic              en,
  output logic              overflow,
  output logic [7:0]        frame_cnt,
  output logic [2:0]        fill
);

  // state | meaning
  // EMPTY | staging bank holds no frame
  // FULL  | staging bank holds a completed frame waiting for !hold
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]        state;
  logic [2:0]        widx;
  logic [DATA_W-1:0] coll  [0:NPTS-1];
  logic [DATA_W-1:0] stage [0:NPTS-1];
  logic [DATA_W-1:0] xr    [0:NPTS-1];
  logic              complete;
  logic              drain;

  assign complete = din_valid && (widx == 3'(NPTS - 1));
  assign drain    = (state == FULL) && !hold;

  function automatic logic [2:0] src_idx(input logic [2:0] k);
`ifdef FRAMER_BITREV_EN
    return {k[0], k[1], k[2]};
`else
    return k;
`endif
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      widx      <= '0;
      en        <= 1'b0;
      overflow  <= 1'b0;
      frame_cnt <= '0;
      for (int k = 0; k < NPTS; k++) begin
        coll[k]  <= '0;
        stage[k] <= '0;
        xr[k]    <= '0;
      end
    end else begin
      if (ovf_clr) overflow <= 1'b0;
      if (flush) begin
        widx  <= '0;
        state <= EMPTY;
        en    <= 1'b0;
      end else begin
        en <= drain;
        if (drain) begin
          for (int k = 0; k < NPTS; k++) xr[k] <= stage[src_idx(k[2:0])];
          frame_cnt <= frame_cnt + 8'd1;
        end
        if (din_valid) begin
          coll[widx] <= din;
          widx       <= widx + 3'd1;
        end
        // a completing frame may land in the stage in the same cycle the old one drains
        if (complete) begin
          if (state == EMPTY || drain) begin
            for (int k = 0; k < NPTS - 1; k++) stage[k] <= coll[k];
            stage[NPTS-1] <= din;
            state         <= FULL;
          end else begin
            overflow <= 1'b1;
          end
        end else if (drain) begin
          state <= EMPTY;
        end
      end
    end
  end

  assign x0   = xr[0];
  assign x1   = xr[1];
  assign x2   = xr[2];
  assign x3   = xr[3];
  assign x4   = xr[4];
  assign x5   = xr[5];
  assign x6   = xr[6];
  assign x7   = xr[7];
  assign fill = widx;

endmodule

// File: tb/tb_fft_input_framer.sv
// Self-checking bench for fft_input_framer against a queue-based frame model.
module tb_fft_input_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        din_valid, hold, flush, ovf_clr;
  logic [15:0] x0, x1, x2, x3, x4, x5, x6, x7;
  logic        en, overflow;
  logic [7:0]  frame_cnt;
  logic [2:0]  fill;
  logic [15:0] xd [8];

  int total = 0;
  int bad   = 0;

  fft_input_framer dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .hold(hold),
    .flush(flush), .ovf_clr(ovf_clr),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
    .en(en), .overflow(overflow), .frame_cnt(frame_cnt), .fill(fill)
  );

  always #5 clk = ~clk;

  assign xd[0] = x0; assign xd[1] = x1; assign xd[2] = x2; assign xd[3] = x3;
  assign xd[4] = x4; assign xd[5] = x5; assign xd[6] = x6; assign xd[7] = x7;

  // reference model: partial frame as a queue, one staged frame, emitted outputs
  logic [15:0] part [$];
  logic [15:0] m_stg [8];
  logic [15:0] m_x [8];
  logic        m_full, m_en, m_ovf;
  int          m_cnt;

  function automatic int omap(int k);
`ifdef FRAMER_BITREV_EN
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
`else
    return k;
`endif
  endfunction

  task automatic model_reset();
    part.delete();
    for (int k = 0; k < 8; k++) begin m_stg[k] = '0; m_x[k] = '0; end
    m_full = 1'b0; m_en = 1'b0; m_ovf = 1'b0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit v, input logic [15:0] d, input bit h, input bit f, input bit c);
    bit nf;
    if (c) m_ovf = 1'b0;
    if (f) begin
      part.delete(); m_full = 1'b0; m_en = 1'b0;
      return;
    end
    m_en = m_full && !h;
    nf   = m_full;
    if (m_en) begin
      for (int k = 0; k < 8; k++) m_x[k] = m_stg[omap(k)];
      m_cnt = (m_cnt + 1) % 256;
      nf = 1'b0;
    end
    if (v) begin
      part.push_back(d);
      if (part.size() == 8) begin
        if (nf) m_ovf = 1'b1;
        else begin
          for (int k = 0; k < 8; k++) m_stg[k] = part[k];
          nf = 1'b1;
        end
        part.delete();
      end
    end
    m_full = nf;
  endtask

  task automatic step(input bit v, input logic [15:0] d, input bit h, input bit f, input bit c);
    din_valid = v; din = d; hold = h; flush = f; ovf_clr = c;
    @(posedge clk);
    model_edge(v, d, h, f, c);
    #1;
  endtask

  task automatic do_reset();
    din_valid = 0; hold = 0; flush = 0; ovf_clr = 0; din = '0;
    #2 rst = 1'b1;
    #4 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; din_valid = 0; hold = 0; flush = 0; ovf_clr = 0; din = '0;
    model_reset();
    #2;
    total++; if (en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", en); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", frame_cnt); end
    total++; if (fill !== 3'd0) begin bad++; $display("FAIL reset_fill got=%0d exp=0", fill); end
    for (int k = 0; k < 8; k++) begin
      total++; if (xd[k] !== 16'd0) begin bad++; $display("FAIL reset_x%0d got=%0d exp=0", k, xd[k]); end
    end
    #10 rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] smp [8] = '{16'd256, 16'd384, 16'd512, 16'd640, 16'd64896, 16'd65024, 16'd65152, 16'd65280};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, smp[i], 0, 0, 0);
      total++; if (en !== 1'b0) begin bad++; $display("FAIL basic_early_en i=%0d got=%b exp=0", i, en); end
    end
    step(0, 16'h0, 0, 0, 0);
    total++; if (en !== 1'b1) begin bad++; $display("FAIL basic_en got=%b exp=1", en); end
    for (int k = 0; k < 8; k++) begin
      total++; if (xd[k] !== smp[omap(k)]) begin bad++; $display("FAIL basic_x%0d got=%0d exp=%0d", k, xd[k], smp[omap(k)]); end
    end
    total++; if (frame_cnt !== 8'd1) begin bad++; $display("FAIL basic_cnt got=%0d exp=1", frame_cnt); end
`ifdef FRAMER_BITREV_EN
    total++; if (x1 !== 16'd64896 || x4 !== 16'd384) begin bad++; $display("FAIL basic_bitrev x1=%0d x4=%0d exp 64896 384", x1, x4); end
`endif
    step(0, 16'h0, 0, 0, 0);
    total++; if (en !== 1'b0) begin bad++; $display("FAIL basic_en_pulse got=%b exp=0", en); end
    total++; if (x0 !== smp[omap(0)]) begin bad++; $display("FAIL basic_hold_x0 got=%0d exp=%0d", x0, smp[omap(0)]); end
  endtask

  task automatic test_gaps();
    logic [15:0] smp [8] = '{16'd256, 16'd384, 16'd512, 16'd640, 16'd64896, 16'd65024, 16'd65152, 16'd65280};
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(i % 2 == 0, (i % 2 == 0) ? smp[i / 2] : 16'($urandom), 0, 0, 0);
      total++; if (en !== 1'b0) begin bad++; $display("FAIL gaps_early_en i=%0d got=%b exp=0", i, en); end
    end
    step(0, 16'($urandom), 0, 0, 0);
    total++; if (en !== 1'b1) begin bad++; $display("FAIL gaps_en got=%b exp=1", en); end
    for (int k = 0; k < 8; k++) begin
      total++; if (xd[k] !== smp[omap(k)]) begin bad++; $display("FAIL gaps_x%0d got=%0d exp=%0d", k, xd[k], smp[omap(k)]); end
    end
  endtask

  task automatic test_hold();
    logic [15:0] fa [8];
    logic [15:0] fb [8];
    for (int k = 0; k < 8; k++) begin fa[k] = 16'($urandom); fb[k] = 16'($urandom); end
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(i < 16, (i < 8) ? fa[i] : (i < 16) ? fb[i - 8] : 16'h0, 1, 0, 0);
      total++; if (en !== 1'b0) begin bad++; $display("FAIL hold_en i=%0d got=%b exp=0", i, en); end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL hold_ovf got=%b exp=1", overflow); end
    total++; if (fill !== 3'd0) begin bad++; $display("FAIL hold_fill got=%0d exp=0", fill); end
    step(0, 16'h0, 0, 0, 0);
    total++; if (en !== 1'b1) begin bad++; $display("FAIL hold_release_en got=%b exp=1", en); end
    for (int k = 0; k < 8; k++) begin
      total++; if (xd[k] !== fa[omap(k)]) begin bad++; $display("FAIL hold_x%0d got=%0d exp=%0d", k, xd[k], fa[omap(k)]); end
    end
    total++; if (frame_cnt !== 8'd1) begin bad++; $display("FAIL hold_cnt got=%0d exp=1", frame_cnt); end
    step(0, 16'h0, 0, 0, 0);
    total++; if (en !== 1'b0) begin bad++; $display("FAIL hold_second_en got=%b exp=0", en); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL hold_ovf_sticky got=%b exp=1", overflow); end
    step(0, 16'h0, 0, 0, 1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL hold_ovf_clr got=%b exp=0", overflow); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    int last;
    do_reset();
    pulses = 0; last = -1;
    for (int i = 1; i <= 34; i++) begin
      step(i <= 32, 16'($urandom), 0, 0, 0);
      total++; if (en !== m_en) begin bad++; $display("FAIL b2b_en cyc=%0d got=%b exp=%b", i, en, m_en); end
      if (en === 1'b1) begin
        if (last >= 0) begin
          total++; if (i - last !== 8) begin bad++; $display("FAIL b2b_spacing got=%0d exp=8", i - last); end
        end
        for (int k = 0; k < 8; k++) begin
          total++; if (xd[k] !== m_x[k]) begin bad++; $display("FAIL b2b_x%0d got=%0d exp=%0d", k, xd[k], m_x[k]); end
        end
        last = i; pulses++;
      end
    end
    total++; if (pulses !== 4) begin bad++; $display("FAIL b2b_pulses got=%0d exp=4", pulses); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_ovf got=%b exp=0", overflow); end
    total++; if (frame_cnt !== 8'd4) begin bad++; $display("FAIL b2b_cnt got=%0d exp=4", frame_cnt); end
  endtask

  task automatic test_async_reset();
    logic [15:0] fq [8];
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 16'($urandom_range(1, 65535)), 0, 0, 0);
    step(0, 16'h0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 16'($urandom), 0, 0, 0);
    total++; if (fill !== 3'd5) begin bad++; $display("FAIL arst_pre_fill got=%0d exp=5", fill); end
    #3 rst = 1'b1;
    #1;
    total++; if (fill !== 3'd0) begin bad++; $display("FAIL arst_fill got=%0d exp=0", fill); end
    total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL arst_cnt got=%0d exp=0", frame_cnt); end
    for (int k = 0; k < 8; k++) begin
      total++; if (xd[k] !== 16'd0) begin bad++; $display("FAIL arst_x%0d got=%0d exp=0", k, xd[k]); end
    end
    #4 rst = 1'b0;
    model_reset();
    for (int k = 0; k < 8; k++) fq[k] = 16'($urandom);
    for (int i = 0; i < 8; i++) step(1, fq[i], 0, 0, 0);
    step(0, 16'h0, 0, 0, 0);
    total++; if (en !== 1'b1) begin bad++; $display("FAIL arst_en got=%b exp=1", en); end
    for (int k = 0; k < 8; k++) begin
      total++; if (xd[k] !== fq[omap(k)]) begin bad++; $display("FAIL arst_x%0d_after got=%0d exp=%0d", k, xd[k], fq[omap(k)]); end
    end
  endtask

  task automatic test_flush();
    logic [15:0] fp [8];
    logic [15:0] fq [8];
    for (int k = 0; k < 8; k++) begin fp[k] = 16'($urandom); fq[k] = 16'($urandom); end
    do_reset();
    for (int i = 0; i < 8; i++) step(1, fp[i], 0, 0, 0);
    step(0, 16'h0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 16'($urandom), 0, 0, 0);
    step(1, 16'($urandom), 0, 1, 0);
    total++; if (fill !== 3'd0) begin bad++; $display("FAIL flush_fill got=%0d exp=0", fill); end
    total++; if (en !== 1'b0) begin bad++; $display("FAIL flush_en got=%b exp=0", en); end
    for (int k = 0; k < 8; k++) begin
      total++; if (xd[k] !== fp[omap(k)]) begin bad++; $display("FAIL flush_held_x%0d got=%0d exp=%0d", k, xd[k], fp[omap(k)]); end
    end
    for (int i = 0; i < 8; i++) step(1, fq[i], 0, 0, 0);
    step(0, 16'h0, 0, 0, 0);
    total++; if (en !== 1'b1) begin bad++; $display("FAIL flush_en_after got=%b exp=1", en); end
    for (int k = 0; k < 8; k++) begin
      total++; if (xd[k] !== fq[omap(k)]) begin bad++; $display("FAIL flush_x%0d got=%0d exp=%0d", k, xd[k], fq[omap(k)]); end
    end
    total++; if (frame_cnt !== 8'd2) begin bad++; $display("FAIL flush_cnt got=%0d exp=2", frame_cnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0);
      total++; if (en !== m_en) begin bad++; $display("FAIL rnd_en cyc=%0d got=%b exp=%b", i, en, m_en); end
      total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", i, overflow, m_ovf); end
      total++; if (frame_cnt !== 8'(m_cnt)) begin bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, frame_cnt, m_cnt); end
      total++; if (fill !== 3'(part.size())) begin bad++; $display("FAIL rnd_fill cyc=%0d got=%0d exp=%0d", i, fill, part.size()); end
      for (int k = 0; k < 8; k++) begin
        total++; if (xd[k] !== m_x[k]) begin bad++; $display("FAIL rnd_x%0d cyc=%0d got=%0d exp=%0d", k, i, xd[k], m_x[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_hold();
    test_back_to_back();
    test_async_reset();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
